// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encodings and level placement for the pipelined shifter
package shift_pkg;

    typedef logic [1:0] shift_op_t;

    localparam shift_op_t OP_SLL = 2'b00;
    localparam shift_op_t OP_SRL = 2'b01;
    localparam shift_op_t OP_SRA = 2'b10;
    localparam shift_op_t OP_ROR = 2'b11;

    // Pipeline stage that hosts shift level `level` when `levels` levels are
    // spread over `stages` register stages. Every stage receives at least one
    // level as long as stages <= levels.
    function automatic int level_stage(input int level, input int stages, input int levels);
        return (level * stages) / levels;
    endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one combinational shift-by-AMT level of the barrel shifter
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    input  logic [1:0]       op_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shifted;

    // Shift by the fixed amount; SRA fills from the sign captured at acceptance.
    always_comb begin
        shifted = data_i;
        case (op_i)
            OP_SLL: shifted = data_i << AMT;
            OP_SRL: shifted = data_i >> AMT;
            OP_SRA: shifted = {{AMT{fill_i}}, data_i[WIDTH-1:AMT]};
            OP_ROR: shifted = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
            default: shifted = data_i;
        endcase
    end

    assign data_o = enable_i ? shifted : data_i;

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined SLL/SRL/SRA/ROR unit with valid/ready at both ends
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5,
    localparam int SHAMT_W    = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LAST = PIPE_STAGES - 1;

    // One global advance: the whole pipe moves or the whole pipe holds.
    logic advance;

    // Stage registers: shifted data plus everything later levels still need.
    logic               valid_q [PIPE_STAGES];
    logic [WIDTH-1:0]   data_q  [PIPE_STAGES];
    logic [SHAMT_W-1:0] shamt_q [PIPE_STAGES];
    logic [1:0]         op_q    [PIPE_STAGES];
    logic               fill_q  [PIPE_STAGES];
    logic [TAG_W-1:0]   tag_q   [PIPE_STAGES];

    // Stage inputs: stage 0 takes the accepted operation, stage s the register of s-1.
    logic               valid_d  [PIPE_STAGES];
    logic [WIDTH-1:0]   data_src [PIPE_STAGES];
    logic [SHAMT_W-1:0] shamt_d  [PIPE_STAGES];
    logic [1:0]         op_d     [PIPE_STAGES];
    logic               fill_d   [PIPE_STAGES];
    logic [TAG_W-1:0]   tag_d    [PIPE_STAGES];

    // Stage outputs after that stage's shift levels.
    logic [WIDTH-1:0]   data_d   [PIPE_STAGES];

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_src
        if (s == 0) begin : g_entry
            assign valid_d[s]  = in_valid;
            assign data_src[s] = in_data;
            assign shamt_d[s]  = in_shamt;
            assign op_d[s]     = in_op;
            // Sign is sampled once here so SRA never depends on partially shifted data.
            assign fill_d[s]   = in_data[WIDTH-1];
            assign tag_d[s]    = in_tag;
        end else begin : g_carry
            assign valid_d[s]  = valid_q[s-1];
            assign data_src[s] = data_q[s-1];
            assign shamt_d[s]  = shamt_q[s-1];
            assign op_d[s]     = op_q[s-1];
            assign fill_d[s]   = fill_q[s-1];
            assign tag_d[s]    = tag_q[s-1];
        end
    end

    // Level k shifts by 2^k and lives in stage level_stage(k); levels sharing a
    // stage are chained combinationally, the last one feeds the stage register.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
        localparam int STG      = level_stage(k, PIPE_STAGES, SHAMT_W);
        localparam bit FIRST    = (k == 0) ? 1'b1
                                : (level_stage(k - 1, PIPE_STAGES, SHAMT_W) != STG);
        localparam bit LAST_LVL = (k == SHAMT_W - 1) ? 1'b1
                                : (level_stage(k + 1, PIPE_STAGES, SHAMT_W) != STG);

        logic [WIDTH-1:0] lvl_in;
        logic [WIDTH-1:0] lvl_out;

        if (FIRST) begin : g_head
            assign lvl_in = data_src[STG];
        end else begin : g_chain
            assign lvl_in = g_level[k - 1].lvl_out;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_level (
            .data_i   (lvl_in),
            .enable_i (shamt_d[STG][k]),
            .op_i     (op_d[STG]),
            .fill_i   (fill_d[STG]),
            .data_o   (lvl_out)
        );

        if (LAST_LVL) begin : g_tail
            assign data_d[STG] = lvl_out;
        end
    end

    // Advance all stages together; payload loads only behind a valid op so the
    // output keeps its last value through bubbles and while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                shamt_q[s] <= '0;
                op_q[s]    <= '0;
                fill_q[s]  <= 1'b0;
                tag_q[s]   <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                if (valid_d[s]) begin
                    data_q[s]  <= data_d[s];
                    shamt_q[s] <= shamt_d[s];
                    op_q[s]    <= op_d[s];
                    fill_q[s]  <= fill_d[s];
                    tag_q[s]   <= tag_d[s];
                end
            end
        end
    end

    // Control fields of the final stage have no consumer past the output.
    logic unused_tail;
    assign unused_tail = ^{shamt_q[LAST], op_q[LAST], fill_q[LAST]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - scoreboard bench for pipelined_shifter
module tb_pipelined_shifter;
    import shift_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          edge_n;
        bit          stalled;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          edge_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    // Main DUT, default configuration.
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    // Two WIDTH=8 lanes: lane 0 PIPE_STAGES=1, lane 1 PIPE_STAGES=3.
    logic       l_in_valid  [2];
    logic       l_in_ready  [2];
    logic [7:0] l_in_data   [2];
    logic [2:0] l_in_shamt  [2];
    logic [1:0] l_in_op     [2];
    logic [4:0] l_in_tag    [2];
    logic       l_out_valid [2];
    logic       l_out_ready [2];
    logic [7:0] l_out_data  [2];
    logic [4:0] l_out_tag   [2];

    exp_t sb[$];
    exp_t sbl[2][$];

    pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)) dut (
        .clock(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    pipelined_shifter #(.WIDTH(8), .PIPE_STAGES(1), .TAG_W(5)) dut_p1 (
        .clock(clk), .reset(rst),
        .in_valid(l_in_valid[0]), .in_ready(l_in_ready[0]), .in_data(l_in_data[0]),
        .in_shamt(l_in_shamt[0]), .in_op(l_in_op[0]), .in_tag(l_in_tag[0]),
        .out_valid(l_out_valid[0]), .out_ready(l_out_ready[0]),
        .out_data(l_out_data[0]), .out_tag(l_out_tag[0])
    );

    pipelined_shifter #(.WIDTH(8), .PIPE_STAGES(3), .TAG_W(5)) dut_p3 (
        .clock(clk), .reset(rst),
        .in_valid(l_in_valid[1]), .in_ready(l_in_ready[1]), .in_data(l_in_data[1]),
        .in_shamt(l_in_shamt[1]), .in_op(l_in_op[1]), .in_tag(l_in_tag[1]),
        .out_valid(l_out_valid[1]), .out_ready(l_out_ready[1]),
        .out_data(l_out_data[1]), .out_tag(l_out_tag[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Bit-by-bit reference: each result bit picks its source bit or the fill.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                              input logic [1:0] op, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00:   r[i] = (i - sh >= 0) ? d[i - sh] : 1'b0;
                2'b01:   r[i] = (i + sh < w) ? d[i + sh] : 1'b0;
                2'b10:   r[i] = (i + sh < w) ? d[i + sh] : d[w - 1];
                default: r[i] = d[(i + sh) % w];
            endcase
        end
        return r;
    endfunction

    // Drive the main DUT for one cycle and report what the coming edge will do.
    task automatic drive_main(input logic v, input logic [31:0] d, input logic [4:0] sh,
                              input logic [1:0] op, input logic [4:0] tg, input logic ordy,
                              output logic acc, output logic emit, output logic ov,
                              output logic ir, output logic [31:0] od, output logic [4:0] ot,
                              output int en);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_shamt  = sh;
        in_op     = op;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        ov   = out_valid;
        ir   = in_ready;
        od   = out_data;
        ot   = out_tag;
        acc  = v && in_ready;
        emit = out_valid && ordy;
        en   = edge_cnt + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        checks++; if (l_out_valid[0] !== 1'b0 || l_out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL reset_lane_valid got=%b%b exp=00", l_out_valid[1], l_out_valid[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_srl_stream();
        logic acc, emit, ov, ir;
        logic [31:0] od;
        logic [4:0] ot;
        int en, nsent, nrecv, last_emit;
        exp_t e;
        nsent = 0; nrecv = 0; last_emit = -1;
        for (int c = 0; c < 120 && nrecv < 32; c++) begin
            drive_main(nsent < 32, 32'h2AAAAAAA, 5'(nsent), OP_SRL, 5'(nsent), 1'b1,
                       acc, emit, ov, ir, od, ot, en);
            if (acc) begin
                e.data = 32'h2AAAAAAA >> nsent; e.tag = 5'(nsent); e.edge_n = en; e.stalled = 0;
                sb.push_back(e);
                nsent++;
            end
            if (emit) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL srl_extra got tag=%0d exp=none", ot);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data) begin errors++; $display("FAIL srl_data shamt=%0d got=%h exp=%h", e.tag, od, e.data); end
                    checks++; if (ot !== e.tag) begin errors++; $display("FAIL srl_tag got=%0d exp=%0d", ot, e.tag); end
                    checks++; if (en - e.edge_n !== 2) begin errors++; $display("FAIL srl_latency got=%0d exp=2", en - e.edge_n); end
                    if (last_emit >= 0) begin
                        checks++; if (en !== last_emit + 1) begin errors++; $display("FAIL srl_throughput gap got=%0d exp=1", en - last_emit); end
                    end
                end
                nrecv++;
                last_emit = en;
            end
        end
        checks++; if (nrecv !== 32) begin errors++; $display("FAIL srl_count got=%0d exp=32", nrecv); end
    endtask

    task automatic test_ops_table();
        logic [31:0] t_d [12];
        logic [4:0]  t_s [12];
        logic [1:0]  t_o [12];
        logic [31:0] t_x [12];
        logic acc, emit, ov, ir;
        logic [31:0] od;
        logic [4:0] ot;
        int en, nsent, nrecv;
        exp_t e;
        t_d[0]  = 32'hAAAAAAAA; t_s[0]  = 4;  t_o[0]  = OP_SRA; t_x[0]  = 32'hFAAAAAAA;
        t_d[1]  = 32'h7FFFFFF0; t_s[1]  = 4;  t_o[1]  = OP_SRA; t_x[1]  = 32'h07FFFFFF;
        t_d[2]  = 32'h00000001; t_s[2]  = 31; t_o[2]  = OP_SLL; t_x[2]  = 32'h80000000;
        t_d[3]  = 32'h00000001; t_s[3]  = 1;  t_o[3]  = OP_ROR; t_x[3]  = 32'h80000000;
        t_d[4]  = 32'h12345678; t_s[4]  = 8;  t_o[4]  = OP_ROR; t_x[4]  = 32'h78123456;
        t_d[5]  = 32'hDEADBEEF; t_s[5]  = 0;  t_o[5]  = OP_SLL; t_x[5]  = 32'hDEADBEEF;
        t_d[6]  = 32'hDEADBEEF; t_s[6]  = 0;  t_o[6]  = OP_SRL; t_x[6]  = 32'hDEADBEEF;
        t_d[7]  = 32'hDEADBEEF; t_s[7]  = 0;  t_o[7]  = OP_SRA; t_x[7]  = 32'hDEADBEEF;
        t_d[8]  = 32'hDEADBEEF; t_s[8]  = 0;  t_o[8]  = OP_ROR; t_x[8]  = 32'hDEADBEEF;
        t_d[9]  = 32'h80000000; t_s[9]  = 31; t_o[9]  = OP_SRA; t_x[9]  = 32'hFFFFFFFF;
        t_d[10] = 32'h80000001; t_s[10] = 31; t_o[10] = OP_SRL; t_x[10] = 32'h00000001;
        t_d[11] = 32'h00000001; t_s[11] = 31; t_o[11] = OP_ROR; t_x[11] = 32'h00000002;
        nsent = 0; nrecv = 0;
        for (int c = 0; c < 60 && nrecv < 12; c++) begin
            if (nsent < 12)
                drive_main(1'b1, t_d[nsent], t_s[nsent], t_o[nsent], 5'(nsent + 1), 1'b1,
                           acc, emit, ov, ir, od, ot, en);
            else
                drive_main(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, ov, ir, od, ot, en);
            if (acc) begin
                e.data = t_x[nsent]; e.tag = 5'(nsent + 1); e.edge_n = en; e.stalled = 0;
                sb.push_back(e);
                nsent++;
            end
            if (emit) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL ops_extra got tag=%0d exp=none", ot);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data) begin errors++; $display("FAIL ops_data entry=%0d got=%h exp=%h", e.tag - 1, od, e.data); end
                    checks++; if (ot !== e.tag) begin errors++; $display("FAIL ops_tag got=%0d exp=%0d", ot, e.tag); end
                end
                nrecv++;
            end
        end
        checks++; if (nrecv !== 12) begin errors++; $display("FAIL ops_count got=%0d exp=12", nrecv); end
    endtask

    task automatic test_backpressure();
        logic acc, emit, ov, ir, ordy;
        logic [31:0] od, frozen_d, d;
        logic [4:0] ot, frozen_t;
        int en, next, recv, held;
        bit have_frozen;
        exp_t e;
        next = 1; recv = 0; held = 0; have_frozen = 0;
        frozen_d = '0; frozen_t = '0;
        for (int c = 0; c < 40 && recv < 4; c++) begin
            ordy = (c >= 5);
            d = 32'h00000F00 * next;
            drive_main(next <= 4, d, 5'(next), OP_SLL, 5'(next), ordy,
                       acc, emit, ov, ir, od, ot, en);
            if (ov && !ordy) begin
                held++;
                checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, ir); end
                if (!have_frozen) begin
                    frozen_d = od; frozen_t = ot; have_frozen = 1;
                    checks++; if (ot !== 5'd1) begin errors++; $display("FAIL bp_first_tag got=%0d exp=1", ot); end
                end else begin
                    checks++; if (od !== frozen_d) begin errors++; $display("FAIL bp_data_frozen got=%h exp=%h", od, frozen_d); end
                    checks++; if (ot !== frozen_t) begin errors++; $display("FAIL bp_tag_frozen got=%0d exp=%0d", ot, frozen_t); end
                end
            end
            if (acc) begin
                e.data = ref_shift(d, next, OP_SLL, 32); e.tag = 5'(next); e.edge_n = en; e.stalled = 0;
                sb.push_back(e);
                next++;
            end
            if (emit) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL bp_duplicate got tag=%0d exp=none", ot);
                end else begin
                    e = sb.pop_front();
                    if (ot !== e.tag) begin errors++; $display("FAIL bp_order got=%0d exp=%0d", ot, e.tag); end
                    checks++; if (od !== e.data) begin errors++; $display("FAIL bp_data got=%h exp=%h", od, e.data); end
                end
                recv++;
            end
        end
        checks++; if (held !== 3) begin errors++; $display("FAIL bp_held_cycles got=%0d exp=3", held); end
        checks++; if (recv !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", recv); end
        drive_main(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, ov, ir, od, ot, en);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", ov); end
    endtask

    task automatic test_reset_midflight();
        logic acc, emit, ov, ir;
        logic [31:0] od;
        logic [4:0] ot;
        int en, acc_edge;
        bit done;
        sb.delete();
        drive_main(1'b1, 32'hA5A50000, 5'd4, OP_SRL, 5'd20, 1'b1, acc, emit, ov, ir, od, ot, en);
        drive_main(1'b1, 32'h5A5A0000, 5'd4, OP_SRL, 5'd21, 1'b1, acc, emit, ov, ir, od, ot, en);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_async_data got=%h exp=0", out_data); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL mid_async_tag got=%h exp=0", out_tag); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_main(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, ov, ir, od, ot, en);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_ghost cycle=%0d got tag=%0d exp=none", c, ot); end
        end
        drive_main(1'b1, 32'hF0000000, 5'd4, OP_SRA, 5'd22, 1'b1, acc, emit, ov, ir, od, ot, en);
        acc_edge = en;
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL mid_accept got=%b exp=1", acc); end
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            drive_main(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, ov, ir, od, ot, en);
            if (emit) begin
                done = 1;
                checks++; if (od !== 32'hFF000000) begin errors++; $display("FAIL mid_new_data got=%h exp=ff000000", od); end
                checks++; if (ot !== 5'd22) begin errors++; $display("FAIL mid_new_tag got=%0d exp=22", ot); end
                checks++; if (en - acc_edge !== 2) begin errors++; $display("FAIL mid_new_latency got=%0d exp=2", en - acc_edge); end
            end
        end
        if (!done) begin
            checks++; errors++; $display("FAIL mid_new_timeout got=none exp=tag 22");
        end
    endtask

    task automatic test_sweep_w8();
        localparam int N = 120;
        int sent [2];
        int recv [2];
        int lane_p [2];
        int en, lat;
        exp_t e;
        sent[0] = 0; sent[1] = 0; recv[0] = 0; recv[1] = 0;
        lane_p[0] = 1; lane_p[1] = 3;
        for (int c = 0; c < 3000 && !(recv[0] == N && recv[1] == N); c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                l_out_ready[l] = ($urandom_range(0, 3) != 0);
                l_in_valid[l]  = (sent[l] < N) && ($urandom_range(0, 4) != 0);
                l_in_data[l]   = 8'($urandom);
                l_in_shamt[l]  = 3'($urandom);
                l_in_op[l]     = 2'($urandom);
                l_in_tag[l]    = 5'(sent[l]);
            end
            #1;
            en = edge_cnt + 1;
            for (int l = 0; l < 2; l++) begin
                if (l_out_valid[l] && !l_out_ready[l]) begin
                    for (int i = 0; i < sbl[l].size(); i++) sbl[l][i].stalled = 1;
                end
                if (l_in_valid[l] && l_in_ready[l]) begin
                    e.data = ref_shift({24'h0, l_in_data[l]}, int'(l_in_shamt[l]), l_in_op[l], 8);
                    e.tag = l_in_tag[l]; e.edge_n = en; e.stalled = 0;
                    sbl[l].push_back(e);
                    sent[l]++;
                end
                if (l_out_valid[l] && l_out_ready[l]) begin
                    checks++;
                    if (sbl[l].size() == 0) begin
                        errors++; $display("FAIL sweep_extra lane=%0d got tag=%0d exp=none", l, l_out_tag[l]);
                    end else begin
                        e = sbl[l].pop_front();
                        lat = en - e.edge_n;
                        if (l_out_data[l] !== e.data[7:0]) begin
                            errors++; $display("FAIL sweep_data lane=%0d tag=%0d got=%h exp=%h", l, e.tag, l_out_data[l], e.data[7:0]);
                        end
                        checks++; if (l_out_tag[l] !== e.tag) begin
                            errors++; $display("FAIL sweep_tag lane=%0d got=%0d exp=%0d", l, l_out_tag[l], e.tag);
                        end
                        checks++;
                        if (!e.stalled && lat !== lane_p[l]) begin
                            errors++; $display("FAIL sweep_latency lane=%0d got=%0d exp=%0d", l, lat, lane_p[l]);
                        end else if (e.stalled && lat <= lane_p[l]) begin
                            errors++; $display("FAIL sweep_stalled_latency lane=%0d got=%0d exp>%0d", l, lat, lane_p[l]);
                        end
                    end
                    recv[l]++;
                end
            end
        end
        for (int l = 0; l < 2; l++) begin
            checks++; if (recv[l] !== N) begin errors++; $display("FAIL sweep_count lane=%0d got=%0d exp=%0d", l, recv[l], N); end
            l_in_valid[l] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int l = 0; l < 2; l++) begin
            l_in_valid[l]  = 1'b0;
            l_in_data[l]   = '0;
            l_in_shamt[l]  = '0;
            l_in_op[l]     = '0;
            l_in_tag[l]    = '0;
            l_out_ready[l] = 1'b1;
        end
        test_reset();
        test_srl_stream();
        test_ops_table();
        test_backpressure();
        test_reset_midflight();
        test_sweep_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
